// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register: captures decode outputs, splits the EX control bundle,
// forms the jump target, and supports hazard stall/flush with a saturating bubble counter.
module id_ex_pipe_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 jump,
  input  logic [DATA_W-5:0]    jaddr_in,
  input  logic [1:0]           wb_in,
  input  logic [2:0]           m_in,
  input  logic [ALUOP_W+1:0]   ex_in,
  input  logic [DATA_W-1:0]    pc4_in,
  input  logic [DATA_W-1:0]    rs_data_in,
  input  logic [DATA_W-1:0]    rt_data_in,
  input  logic [DATA_W-1:0]    imm_in,
  input  logic [REG_W-1:0]     rt_addr_in,
  input  logic [REG_W-1:0]     rd_addr_in,
  output logic [1:0]           wb_out,
  output logic [2:0]           m_out,
  output logic                 reg_dst,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 alu_src,
  output logic [DATA_W-1:0]    pc4_out,
  output logic [DATA_W-1:0]    rs_data_out,
  output logic [DATA_W-1:0]    rt_data_out,
  output logic [DATA_W-1:0]    imm_out,
  output logic [REG_W-1:0]     rt_addr_out,
  output logic [REG_W-1:0]     rd_addr_out,
  output logic [DATA_W-1:0]    jump_target,
  output logic                 jump_out,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int unsigned EX_W = ALUOP_W + 2;

  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment of the bubble counter
  always_comb begin
    cnt_inc = bubble_cnt;
    if (bubble_cnt != {CNT_W{1'b1}}) begin
      cnt_inc = bubble_cnt + CNT_W'(1);
    end
  end

  // Pipeline register: rst > flush > stall > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_out      <= '0;
      m_out       <= '0;
      reg_dst     <= 1'b0;
      alu_op      <= '0;
      alu_src     <= 1'b0;
      pc4_out     <= '0;
      rs_data_out <= '0;
      rt_data_out <= '0;
      imm_out     <= '0;
      rt_addr_out <= '0;
      rd_addr_out <= '0;
      jump_target <= '0;
      jump_out    <= 1'b0;
      valid_out   <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      wb_out      <= '0;
      m_out       <= '0;
      reg_dst     <= 1'b0;
      alu_op      <= '0;
      alu_src     <= 1'b0;
      pc4_out     <= '0;
      rs_data_out <= '0;
      rt_data_out <= '0;
      imm_out     <= '0;
      rt_addr_out <= '0;
      rd_addr_out <= '0;
      jump_target <= '0;
      jump_out    <= 1'b0;
      valid_out   <= 1'b0;
      bubble_cnt  <= cnt_inc;
    end else if (!stall) begin
      pc4_out     <= pc4_in;
      rs_data_out <= rs_data_in;
      rt_data_out <= rt_data_in;
      imm_out     <= imm_in;
      rt_addr_out <= rt_addr_in;
      rd_addr_out <= rd_addr_in;
      jump_target <= {pc4_in[DATA_W-1 -: 4], jaddr_in};
      valid_out   <= in_valid;
      if (in_valid) begin
        wb_out   <= wb_in;
        m_out    <= m_in;
        reg_dst  <= ex_in[EX_W-1];
        alu_op   <= ex_in[ALUOP_W:1];
        alu_src  <= ex_in[0];
        jump_out <= jump;
      end else begin
        // Upstream bubble: squash control so nothing downstream acts on it
        wb_out     <= '0;
        m_out      <= '0;
        reg_dst    <= 1'b0;
        alu_op     <= '0;
        alu_src    <= 1'b0;
        jump_out   <= 1'b0;
        bubble_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed and randomized steps against a behavioural model,
// with a second narrow-counter instance for saturation.
module tb_id_ex_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, jump;
  logic [27:0] jaddr_in;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [4:0]  ex_in;
  logic [31:0] pc4_in, rs_data_in, rt_data_in, imm_in;
  logic [4:0]  rt_addr_in, rd_addr_in;

  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic        reg_dst, alu_src, jump_out, valid_out;
  logic [2:0]  alu_op;
  logic [31:0] pc4_out, rs_data_out, rt_data_out, imm_out, jump_target;
  logic [4:0]  rt_addr_out, rd_addr_out;
  logic [7:0]  bubble_cnt;

  logic [1:0]  s_wb_out;
  logic [2:0]  s_m_out;
  logic        s_reg_dst, s_alu_src, s_jump_out, s_valid_out;
  logic [2:0]  s_alu_op;
  logic [31:0] s_pc4_out, s_rs_data_out, s_rt_data_out, s_imm_out, s_jump_target;
  logic [4:0]  s_rt_addr_out, s_rd_addr_out;
  logic [1:0]  s_bubble_cnt;

  int total = 0;
  int bad = 0;

  // Reference state
  int unsigned e_wb, e_m, e_rd, e_op, e_src, e_j, e_v, e_cnt, e_cnt2;
  int unsigned e_pc4, e_rs, e_rt, e_imm, e_rta, e_rda, e_jt;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .jump(jump),
    .jaddr_in(jaddr_in), .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .pc4_in(pc4_in),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
    .wb_out(wb_out), .m_out(m_out), .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src),
    .pc4_out(pc4_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
    .rt_addr_out(rt_addr_out), .rd_addr_out(rd_addr_out), .jump_target(jump_target),
    .jump_out(jump_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .jump(jump),
    .jaddr_in(jaddr_in), .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .pc4_in(pc4_in),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
    .wb_out(s_wb_out), .m_out(s_m_out), .reg_dst(s_reg_dst), .alu_op(s_alu_op),
    .alu_src(s_alu_src), .pc4_out(s_pc4_out), .rs_data_out(s_rs_data_out),
    .rt_data_out(s_rt_data_out), .imm_out(s_imm_out), .rt_addr_out(s_rt_addr_out),
    .rd_addr_out(s_rd_addr_out), .jump_target(s_jump_target), .jump_out(s_jump_out),
    .valid_out(s_valid_out), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_clear();
    e_wb = 0; e_m = 0; e_rd = 0; e_op = 0; e_src = 0; e_j = 0; e_v = 0;
    e_pc4 = 0; e_rs = 0; e_rt = 0; e_imm = 0; e_rta = 0; e_rda = 0; e_jt = 0;
  endtask

  // What one clock edge should do, given the inputs now on the pins
  task automatic model_edge();
    if (flush) begin
      model_clear();
      e_cnt  = sat_inc(e_cnt, 255);
      e_cnt2 = sat_inc(e_cnt2, 3);
    end else if (!stall) begin
      e_pc4 = pc4_in; e_rs = rs_data_in; e_rt = rt_data_in; e_imm = imm_in;
      e_rta = rt_addr_in; e_rda = rd_addr_in;
      e_jt  = (pc4_in & 32'hF000_0000) | 32'(jaddr_in);
      e_v   = in_valid;
      if (in_valid) begin
        e_wb = wb_in; e_m = m_in;
        e_rd = ex_in / 16; e_op = (ex_in / 2) % 8; e_src = ex_in % 2;
        e_j  = jump;
      end else begin
        e_wb = 0; e_m = 0; e_rd = 0; e_op = 0; e_src = 0; e_j = 0;
        e_cnt  = sat_inc(e_cnt, 255);
        e_cnt2 = sat_inc(e_cnt2, 3);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wb"},   32'(wb_out),      e_wb);
    chk({tag, ".m"},    32'(m_out),       e_m);
    chk({tag, ".rdst"}, 32'(reg_dst),     e_rd);
    chk({tag, ".aop"},  32'(alu_op),      e_op);
    chk({tag, ".asrc"}, 32'(alu_src),     e_src);
    chk({tag, ".pc4"},  pc4_out,          e_pc4);
    chk({tag, ".rs"},   rs_data_out,      e_rs);
    chk({tag, ".rt"},   rt_data_out,      e_rt);
    chk({tag, ".imm"},  imm_out,          e_imm);
    chk({tag, ".rta"},  32'(rt_addr_out), e_rta);
    chk({tag, ".rda"},  32'(rd_addr_out), e_rda);
    chk({tag, ".jt"},   jump_target,      e_jt);
    chk({tag, ".jo"},   32'(jump_out),    e_j);
    chk({tag, ".v"},    32'(valid_out),   e_v);
    chk({tag, ".cnt"},  32'(bubble_cnt),  e_cnt);
    chk({tag, ".cnt2"}, 32'(s_bubble_cnt), e_cnt2);
    chk({tag, ".s_v"},  32'(s_valid_out), e_v);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic rand_inputs();
    jump = 1'($urandom); jaddr_in = 28'($urandom); wb_in = 2'($urandom);
    m_in = 3'($urandom); ex_in = 5'($urandom); pc4_in = $urandom;
    rs_data_in = $urandom; rt_data_in = $urandom; imm_in = $urandom;
    rt_addr_in = 5'($urandom); rd_addr_in = 5'($urandom); in_valid = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    e_cnt = 0; e_cnt2 = 0;
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_vector();
    in_valid = 1'b1; ex_in = 5'b1_010_1; wb_in = 2'b11; m_in = 3'b010;
    pc4_in = 32'hA000_0104; jaddr_in = 28'h000_0400; jump = 1'b1;
    rs_data_in = 32'h1111_1111; rt_data_in = 32'h2222_2222; imm_in = 32'hFFFF_FFF0;
    rt_addr_in = 5'd7; rd_addr_in = 5'd9;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    load_vector();
    in_valid = 1'b0;
    #1;
    model_clear();
    e_cnt = 0; e_cnt2 = 0;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Load: spec vector
    load_vector();
    step("load");
    chk("load.jt_abs", jump_target, 32'hA000_0400);
    chk("load.aop_abs", 32'(alu_op), 32'd2);
    chk("load.wb_abs", 32'(wb_out), 32'd3);

    // Stall for 3 cycles with changed inputs, then release
    stall = 1'b1;
    rand_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.jt_frozen", jump_target, 32'hA000_0400);
    end
    stall = 1'b0;
    step("unstall");

    // Flush wins over stall
    flush = 1'b1; stall = 1'b1;
    step("flush_stall");
    chk("flush_stall.cnt_abs", 32'(bubble_cnt), 32'd1);
    flush = 1'b0; stall = 1'b0;

    // Upstream bubble
    load_vector();
    in_valid = 1'b0; jump = 1'b1; wb_in = 2'b11; rs_data_in = 32'h0000_1234;
    step("bubble");
    chk("bubble.rs_abs", rs_data_out, 32'h0000_1234);
    chk("bubble.cnt_abs", 32'(bubble_cnt), 32'd2);

    // Async reset between edges with nonzero state
    load_vector();
    step("preload");
    #2;
    do_reset();

    // Saturation: 5 consecutive flushes
    load_vector();
    flush = 1'b1;
    for (int i = 0; i < 5; i++) step("sat");
    chk("sat.cnt2_abs", 32'(s_bubble_cnt), 32'd3);
    chk("sat.cnt_abs", 32'(bubble_cnt), 32'd5);
    flush = 1'b0;

    // Async reset in the middle of a stall
    load_vector();
    step("preload2");
    stall = 1'b1;
    step("stall2");
    #2;
    do_reset();
    stall = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    stall = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
